// File: rtl/serdes_train_tx.sv
// -----------------------------------------------------------------------------
// serdes_train_tx
//
// Transmit-side training generator for a SerDes link. When REQ_I rises, it
// drives a fixed training word onto the OSERDES parallel input and inserts a
// marker word at a fixed spacing. Training continues until the receiver reports
// bit alignment. The block then sends a guard interval of training words and
// after that hands the serializer over to the user payload path. All logic
// runs in the OSERDES parallel-clock domain.
//
// Ports
//   CLK_I            in   1             OSERDES parallel clock, rising edge
//   RST_I            in   1             synchronous active-high reset
//   REQ_I            in   1             training request (level; rising edge
//                                       starts or restarts training)
//   RX_ALIGN_DONE_I  in   1             receiver alignment done (CLK_I domain)
//   DATA_I           in   C_DATA_WIDTH  payload word
//   DATA_VALID_I     in   1             DATA_I qualifier
//   DATA_O           out  C_DATA_WIDTH  registered word to the serializer
//   TRAINING_O       out  1             high while in TRAIN or HOLD
//   READY_O          out  1             high in PAYLOAD; payload accepted only
//                                       while high
//   TIMEOUT_O        out  1             one-cycle pulse on training timeout
// -----------------------------------------------------------------------------
module serdes_train_tx #(
    parameter int unsigned                C_DATA_WIDTH  = 4,
    parameter logic [C_DATA_WIDTH-1:0]    C_TRAIN_WORD  = C_DATA_WIDTH'(4'b0101),
    parameter logic [C_DATA_WIDTH-1:0]    C_MARK_WORD   = C_DATA_WIDTH'(4'b0011),
    parameter int unsigned                C_MARK_PERIOD = 8,
    parameter int unsigned                C_MIN_TRAIN   = 16,
    parameter int unsigned                C_HOLD        = 4,
    parameter int unsigned                C_TIMEOUT     = 1000,
    parameter logic [C_DATA_WIDTH-1:0]    C_IDLE_WORD   = '0
) (
    input  logic                    CLK_I,
    input  logic                    RST_I,
    input  logic                    REQ_I,
    input  logic                    RX_ALIGN_DONE_I,
    input  logic [C_DATA_WIDTH-1:0] DATA_I,
    input  logic                    DATA_VALID_I,
    output logic [C_DATA_WIDTH-1:0] DATA_O,
    output logic                    TRAINING_O,
    output logic                    READY_O,
    output logic                    TIMEOUT_O
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TRAIN,
        ST_HOLD,
        ST_PAYLOAD
    } state_t;

    // Terminal counts. The HOLD and marker values are guarded so that a
    // zero-valued parameter does not wrap to 0xFFFF. In those configurations
    // the corresponding path is never used.
    localparam logic [15:0] MIN_M1     = 16'(C_MIN_TRAIN - 1);
    localparam logic [15:0] TIMEOUT_M1 = 16'(C_TIMEOUT - 1);
    localparam logic [15:0] HOLD_M1    = (C_HOLD == 0) ? 16'd0 : 16'(C_HOLD - 1);
    localparam logic [15:0] MARK_M1    = (C_MARK_PERIOD == 0) ? 16'd0 : 16'(C_MARK_PERIOD - 1);
    localparam bit          MARK_EN    = (C_MARK_PERIOD != 0);
    localparam bit          HOLD_EN    = (C_HOLD != 0);

    state_t                  state_q, state_d;
    logic [15:0]             word_cnt_q, word_cnt_d;
    logic [15:0]             mark_cnt_q, mark_cnt_d;
    logic                    req_d_q;
    logic [C_DATA_WIDTH-1:0] data_q, data_d;
    logic                    training_q, training_d;
    logic                    ready_q, ready_d;
    logic                    timeout_q, timeout_d;

    logic                    req_pos;
    logic                    exit_ok;
    logic [15:0]             mark_nxt;
    logic [15:0]             word_inc;

    // Select the marker or training word for a given marker-counter position.
    function automatic logic [C_DATA_WIDTH-1:0] seq_word(input logic [15:0] mark);
        return (MARK_EN && (mark == 16'd0)) ? C_MARK_WORD : C_TRAIN_WORD;
    endfunction

    assign req_pos  = REQ_I & ~req_d_q;

    // word_cnt_q indexes the word currently on DATA_O. When it reaches
    // MIN_M1, C_MIN_TRAIN words have already been driven.
    assign exit_ok  = RX_ALIGN_DONE_I && (word_cnt_q >= MIN_M1);
    assign mark_nxt = (!MARK_EN || (mark_cnt_q == MARK_M1)) ? 16'd0 : mark_cnt_q + 16'd1;
    assign word_inc = (word_cnt_q == 16'hFFFF) ? word_cnt_q : word_cnt_q + 16'd1;

    // Next-state and next-output logic. The registered outputs are computed
    // for the state being entered, so they change on the same edge as the state.
    always_comb begin
        // NOTE: every signal gets a default before the case so that no path
        // leaves one unassigned, which would infer a latch.
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        mark_cnt_d = mark_cnt_q;
        data_d     = C_IDLE_WORD;
        timeout_d  = 1'b0;

        if (req_pos) begin
            // A restart wins in every state and begins the sequence at word 0.
            state_d    = ST_TRAIN;
            word_cnt_d = 16'd0;
            mark_cnt_d = 16'd0;
            data_d     = seq_word(16'd0);
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    data_d = C_IDLE_WORD;
                end

                ST_TRAIN: begin
                    if (exit_ok) begin
                        word_cnt_d = 16'd0;
                        if (HOLD_EN) begin
                            state_d    = ST_HOLD;
                            mark_cnt_d = mark_nxt;
                            data_d     = seq_word(mark_nxt);
                        end else begin
                            // READY_O was low at this edge, so no payload was
                            // accepted. The first payload slot carries idle.
                            state_d = ST_PAYLOAD;
                            data_d  = C_IDLE_WORD;
                        end
                    end else if (word_cnt_q == TIMEOUT_M1) begin
                        timeout_d  = 1'b1;
                        word_cnt_d = 16'd0;
                        mark_cnt_d = 16'd0;
                        data_d     = seq_word(16'd0);
                    end else begin
                        word_cnt_d = word_inc;
                        mark_cnt_d = mark_nxt;
                        data_d     = seq_word(mark_nxt);
                    end
                end

                ST_HOLD: begin
                    if (!RX_ALIGN_DONE_I) begin
                        state_d    = ST_TRAIN;
                        word_cnt_d = 16'd0;
                        mark_cnt_d = 16'd0;
                        data_d     = seq_word(16'd0);
                    end else if (word_cnt_q == HOLD_M1) begin
                        // The first payload slot follows the last guard word.
                        // READY_O rises with it, so that slot is still idle.
                        state_d    = ST_PAYLOAD;
                        word_cnt_d = 16'd0;
                        data_d     = C_IDLE_WORD;
                    end else begin
                        word_cnt_d = word_inc;
                        mark_cnt_d = mark_nxt;
                        data_d     = seq_word(mark_nxt);
                    end
                end

                ST_PAYLOAD: begin
                    // Loss of alignment is ignored here. Retraining happens only
                    // on a new request edge.
                    data_d = DATA_VALID_I ? DATA_I : C_IDLE_WORD;
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        training_d = (state_d == ST_TRAIN) || (state_d == ST_HOLD);
        ready_d    = (state_d == ST_PAYLOAD);
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            // NOTE: state is updated with non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state_q    <= ST_IDLE;
            word_cnt_q <= 16'd0;
            mark_cnt_q <= 16'd0;
            req_d_q    <= 1'b0;
            data_q     <= C_IDLE_WORD;
            training_q <= 1'b0;
            ready_q    <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            mark_cnt_q <= mark_cnt_d;
            req_d_q    <= REQ_I;
            data_q     <= data_d;
            training_q <= training_d;
            ready_q    <= ready_d;
            timeout_q  <= timeout_d;
        end
    end

    assign DATA_O     = data_q;
    assign TRAINING_O = training_q;
    assign READY_O    = ready_q;
    assign TIMEOUT_O  = timeout_q;

endmodule

// File: tb/tb_serdes_train_tx.sv
// -----------------------------------------------------------------------------
// tb_serdes_train_tx
//
// Directed self-checking bench for serdes_train_tx. It instantiates two
// configurations:
//   u_dut4 : defaults (4-bit, markers every 8 words, 4-word hold)
//   u_dut8 : 8-bit, markers disabled, no hold interval
// Before each clock, the expected output word and flags for each DUT are pushed
// to that DUT's scoreboard queue. After the clock they are popped and compared.
// -----------------------------------------------------------------------------
module tb_serdes_train_tx;

    typedef struct packed {
        logic [7:0] data;
        logic       trn;
        logic       rdy;
        logic       to;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst;

    logic       req4, done4, valid4;
    logic [3:0] din4, dout4;
    logic       trn4, rdy4, to4;

    logic       req8, done8, valid8;
    logic [7:0] din8, dout8;
    logic       trn8, rdy8, to8;

    obs_t       q4[$];
    obs_t       q8[$];
    int         n_checks = 0;
    int         n_pass   = 0;

    always #5 clk = ~clk;

    serdes_train_tx u_dut4 (
        .CLK_I           (clk),
        .RST_I           (rst),
        .REQ_I           (req4),
        .RX_ALIGN_DONE_I (done4),
        .DATA_I          (din4),
        .DATA_VALID_I    (valid4),
        .DATA_O          (dout4),
        .TRAINING_O      (trn4),
        .READY_O         (rdy4),
        .TIMEOUT_O       (to4)
    );

    serdes_train_tx #(
        .C_DATA_WIDTH  (8),
        .C_TRAIN_WORD  (8'b0101_0101),
        .C_MARK_WORD   (8'b0011_0011),
        .C_MARK_PERIOD (0),
        .C_HOLD        (0)
    ) u_dut8 (
        .CLK_I           (clk),
        .RST_I           (rst),
        .REQ_I           (req8),
        .RX_ALIGN_DONE_I (done8),
        .DATA_I          (din8),
        .DATA_VALID_I    (valid8),
        .DATA_O          (dout8),
        .TRAINING_O      (trn8),
        .READY_O         (rdy8),
        .TIMEOUT_O       (to8)
    );

    // Expected word for the default DUT at sequence position w: a marker every
    // 8 words starting at word 0, otherwise the training word.
    function automatic logic [7:0] w4(input int w);
        return (w % 8 == 0) ? 8'h03 : 8'h05;
    endfunction

    task automatic exp4(input logic [7:0] d, input logic t, input logic r, input logic o);
        obs_t e;
        e.data = d; e.trn = t; e.rdy = r; e.to = o;
        q4.push_back(e);
    endtask

    task automatic exp8(input logic [7:0] d, input logic t, input logic r, input logic o);
        obs_t e;
        e.data = d; e.trn = t; e.rdy = r; e.to = o;
        q8.push_back(e);
    endtask

    task automatic check_obs(input string tag, input obs_t obs, input obs_t e);
        n_checks++;
        assert (obs === e) n_pass++;
        else $error("FAIL %s: observed data=%h trn=%b rdy=%b to=%b, expected data=%h trn=%b rdy=%b to=%b",
                    tag, obs.data, obs.trn, obs.rdy, obs.to, e.data, e.trn, e.rdy, e.to);
    endtask

    // Advance one clock. Sample 1 ns after the rising edge, then score every
    // queued expectation.
    task automatic tick(input string tag);
        obs_t o;
        @(posedge clk);
        #1;
        if (q4.size() > 0) begin
            o.data = {4'b0000, dout4}; o.trn = trn4; o.rdy = rdy4; o.to = to4;
            check_obs({tag, "/w4"}, o, q4.pop_front());
        end
        if (q8.size() > 0) begin
            o.data = dout8; o.trn = trn8; o.rdy = rdy8; o.to = to8;
            check_obs({tag, "/w8"}, o, q8.pop_front());
        end
    endtask

    // Expect training words w = first..last on the default DUT.
    task automatic train4(input int first, input int last, input string tag);
        for (int w = first; w <= last; w++) begin
            exp4(w4(w), 1'b1, 1'b0, 1'b0);
            tick(tag);
        end
    endtask

    initial begin
        rst = 1'b1;
        req4 = 1'b0; done4 = 1'b0; valid4 = 1'b0; din4 = 4'h0;
        req8 = 1'b0; done8 = 1'b0; valid8 = 1'b0; din8 = 8'h00;

        // Reset state and idle.
        repeat (2) begin
            exp4(8'h00, 0, 0, 0); exp8(8'h00, 0, 0, 0); tick("reset");
        end
        rst = 1'b0;
        exp4(8'h00, 0, 0, 0); exp8(8'h00, 0, 0, 0); tick("idle");

        // Nominal run: done rises during word 5. Exactly 16 training words
        // follow, then 4 hold words with a marker at word 16.
        req4 = 1'b1;
        for (int w = 0; w <= 15; w++) begin
            exp4(w4(w), 1, 0, 0);
            tick("nominal_train");
            if (w == 4) done4 = 1'b1;
        end
        train4(16, 19, "nominal_hold");
        exp4(8'h00, 0, 1, 0); tick("ready_rise");

        // Payload path with one-cycle latency.
        valid4 = 1'b1;
        din4 = 4'hA; exp4(8'h0A, 0, 1, 0); tick("payload_a");
        din4 = 4'hB; exp4(8'h0B, 0, 1, 0); tick("payload_b");
        din4 = 4'hC; exp4(8'h0C, 0, 1, 0); tick("payload_c");

        // Bubbles. Alignment loss is ignored in PAYLOAD.
        done4 = 1'b0;
        valid4 = 1'b0; din4 = 4'hD; exp4(8'h00, 0, 1, 0); tick("bubble_idle");
        valid4 = 1'b1; din4 = 4'hE; exp4(8'h0E, 0, 1, 0); tick("bubble_valid");
        valid4 = 1'b0; din4 = 4'hF; exp4(8'h00, 0, 1, 0); tick("bubble_idle2");

        // Retrain mid-payload. Payload presented on the restart edge must not
        // leak through.
        req4 = 1'b0; valid4 = 1'b1; din4 = 4'h9;
        exp4(8'h09, 0, 1, 0); tick("payload_before_retrain");
        req4 = 1'b1; din4 = 4'h7;
        exp4(8'h03, 1, 0, 0); tick("retrain_marker");
        valid4 = 1'b0;

        // Done drops on hold word 2. Training restarts at word 0 and needs
        // 16 more words, then a full 4-word hold.
        done4 = 1'b1;
        train4(1, 15, "drop_train");
        train4(16, 18, "drop_hold");
        done4 = 1'b0;
        exp4(w4(0), 1, 0, 0); tick("hold_drop_retrain");
        done4 = 1'b1;
        train4(1, 15, "drop_min_train");
        train4(16, 19, "drop_full_hold");
        exp4(8'h00, 0, 1, 0); tick("drop_ready");

        // Timeout: done held low. Expect a pulse every 1000 words, with the
        // marker sequence restarting at word 0.
        req4 = 1'b0; done4 = 1'b0;
        exp4(8'h00, 0, 1, 0); tick("pre_timeout_payload");
        req4 = 1'b1;
        train4(0, 999, "to_round1");
        exp4(w4(0), 1, 0, 1); tick("timeout_pulse1");
        train4(1, 999, "to_round2");
        exp4(w4(0), 1, 0, 1); tick("timeout_pulse2");
        train4(1, 999, "to_round3");
        // Done arrives exactly at the timeout count. Exit wins and no pulse is
        // expected.
        done4 = 1'b1;
        exp4(w4(1000), 1, 0, 0); tick("exit_beats_timeout");
        train4(1001, 1003, "exit_hold");
        exp4(8'h00, 0, 1, 0); tick("exit_ready");

        // Reset mid-training aborts at once. REQ_I held high through reset
        // release counts as a fresh edge, but only once.
        req4 = 1'b0;
        exp4(8'h00, 0, 1, 0); tick("pre_reset_payload");
        req4 = 1'b1;
        train4(0, 5, "pre_reset_train");
        rst = 1'b1;
        exp4(8'h00, 0, 0, 0); tick("reset_abort");
        exp4(8'h00, 0, 0, 0); tick("reset_hold");
        rst = 1'b0;
        exp4(w4(0), 1, 0, 0); tick("req_after_reset");
        train4(1, 3, "req_held_no_restart");

        // 8-bit configuration: no markers, no hold. The exit edge goes
        // straight to PAYLOAD.
        req8 = 1'b1; done8 = 1'b1;
        for (int w = 0; w <= 15; w++) begin
            exp8(8'h55, 1, 0, 0);
            tick("w8_train");
        end
        exp8(8'h00, 0, 1, 0); tick("w8_direct_payload");
        valid8 = 1'b1; din8 = 8'hC3;
        exp8(8'hC3, 0, 1, 0); tick("w8_payload");
        valid8 = 1'b0;
        exp8(8'h00, 0, 1, 0); tick("w8_bubble");

        // Every pushed expectation must have been consumed.
        n_checks++;
        assert ((q4.size() == 0) && (q8.size() == 0)) n_pass++;
        else $error("FAIL scoreboard_drain: observed %0d/%0d left, expected 0/0", q4.size(), q8.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
